decode_hazard_ctrl: RTL
=======================

Name: decode_hazard_ctrl

Overview:
- Pipeline sequencing controller for the decode stage.
- Tracks in-flight register writes in a shift-register scoreboard and detects RAW hazards against the instruction in decode.
- Drives stall, bubble and flush controls for fetch and the IF/ID latch, holds fetch while a branch resolves, and drains the pipe on halt (createdump).
- Sits beside decode. It consumes decoded register selects and control flags, and drives fetch_enable and the pipeline-latch enables.

Parameters:
- REGW, 3, register select width (8 GPRs).
- DEPTH, 3, scoreboard entries behind decode: entry 0 = EX, 1 = MEM, 2 = WB.
- CHECK, 2, number of youngest entries compared for hazards. The WB entry is excluded because the bypassing register file forwards same-cycle writes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode holds a real instruction.
- id_rs_sel  in  REGW  read port 1 select (instr[10:8]).
- id_rs_used  in  1  instruction reads rs.
- id_rt_sel  in  REGW  read port 2 select (instr[7:5]).
- id_rt_used  in  1  instruction reads rt.
- id_wr_sel  in  REGW  resolved write register (after RegDst mux; 7 for JAL).
- id_wr_en  in  1  instruction writes a register.
- id_is_branch  in  1  branch or jump in decode.
- id_halt  in  1  halt/createdump in decode.
- ex_resolve  in  1  branch in EX resolved this cycle.
- ex_taken  in  1  resolved branch taken; qualified by ex_resolve.
- fetch_enable  out  1  PC/IF may advance.
- ifid_hold  out  1  IF/ID latch holds its value.
- id_bubble  out  1  inject NOP into ID/EX.
- ifid_flush  out  1  clear IF/ID to NOP.
- halted  out  1  pipeline drained after halt; sticky.
- busy_mask  out  2**REGW  registers with a pending write in the EX/MEM entries.

Behaviour:
- Reset (rst=0, async):
  - scoreboard cleared; state=RUN.
  - fetch_enable=1, ifid_hold=0, id_bubble=0, ifid_flush=0, halted=0, busy_mask=0.
- Scoreboard:
  - Each entry is {v, reg[REGW-1:0]}. It shifts every cycle: entry i+1 <= entry i; the WB entry falls off.
  - Entry 0 loads {id_valid & id_wr_en & accept, id_wr_sel}. Otherwise it loads v=0 (a bubble).
- hazard = id_valid & ((id_rs_used & match(rs)) | (id_rt_used & match(rt))).
  - match(r) = any entry j < CHECK with v=1 and reg=r.
  - The check is combinational and uses the current scoreboard.
- accept = state==RUN & id_valid & ~hazard & ~flush_now.
- States and transitions:
  - RUN:
    - hazard: fetch_enable=0, ifid_hold=1, id_bubble=1. Decode retries the next cycle; the stall lasts at most CHECK cycles.
    - accept & id_is_branch: go to BR_WAIT.
    - accept & id_halt: go to DRAIN.
  - BR_WAIT:
    - fetch_enable=0, ifid_hold=1, id_bubble=1 every cycle while waiting.
    - ex_resolve & ex_taken: ifid_flush=1 for exactly that cycle, fetch_enable=1, then RUN.
    - ex_resolve & ~ex_taken: fetch_enable=1, no flush, then RUN.
  - DRAIN:
    - fetch_enable=0, ifid_hold=1, id_bubble=1.
    - When all DEPTH entries have v=0: go to HALTED.
  - HALTED:
    - Same holds as DRAIN; halted=1.
    - Leaves only via reset.
- Combinational vs registered outputs:
  - fetch_enable, ifid_hold, id_bubble and ifid_flush are combinational from state, scoreboard and inputs.
  - halted is registered.
  - busy_mask is combinational from the scoreboard.
- Simultaneous events:
  - ex_resolve&ex_taken outside BR_WAIT: ignored.
  - flush_now (taken resolve) overrides hazard and accept that same cycle. The instruction in ID is discarded and no scoreboard entry is made.
  - Hazard plus branch/halt in ID: the stall wins; the branch or halt is accepted only once the hazard clears.
  - id_is_branch & id_halt together: halt takes precedence (DRAIN).
  - id_valid=0: no hazard and no stall; a bubble enters the scoreboard.
- Register 0 is an ordinary register; it gets no special-casing.
- Reset mid-BR_WAIT or mid-DRAIN: immediate return to RUN with an empty scoreboard.

Decomposition:
- Shared package holds:
  - state encoding localparams: RUN=2'd0, BR_WAIT=2'd1, DRAIN=2'd2, HALTED=2'd3.
  - REGW and the NOP encoding used by the flush/bubble consumers.
- One natural sub-module: wr_scoreboard (shift register plus match/busy_mask logic, parameterised by DEPTH and CHECK).
- The FSM and output decode live in decode_hazard_ctrl.

Test Plan:
- RAW stall:
  - Stimulus: ADD writing r3 accepted; next cycle ID reads rs=r3.
  - Required: id_bubble=1 and fetch_enable=0 for 2 cycles. Accepted in cycle 3, once the r3 entry has reached WB.
- No false stall:
  - Stimulus: writer to r5, then a reader of r2/r4 (rs/rt used).
  - Required: no stall; busy_mask=8'b0010_0000 the cycle after acceptance.
- Branch not taken:
  - Stimulus: BEQZ accepted; ex_resolve=1, ex_taken=0 two cycles later.
  - Required: fetch_enable=0 for those 2 cycles, ifid_flush stays 0, state back to RUN.
- Branch taken with hazard collision:
  - Stimulus: in BR_WAIT, ex_resolve=ex_taken=1 while ID shows a hazarding reader.
  - Required: ifid_flush=1 for exactly 1 cycle; no scoreboard entry made for the discarded instruction.
- Halt drain:
  - Stimulus: two writers accepted, then halt.
  - Required: fetch_enable=0 from halt acceptance; halted rises 3 cycles after halt acceptance, when the last writer has left WB; halted stays 1 indefinitely.
- Async reset:
  - Stimulus: assert rst=0 mid-BR_WAIT, between clock edges.
  - Required: outputs return to reset values immediately, before the next edge; after release, a reader of a previously busy register is not stalled.

Source files
------------

// File: rtl/decode_hazard_ctrl_pkg.sv
// ============================================================================
// decode_hazard_ctrl_pkg : shared constants for the decode-stage sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package decode_hazard_ctrl_pkg;

    localparam int REGW  = 3;
    localparam int DEPTH = 3;
    localparam int CHECK = 2;

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] BR_WAIT = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;
    localparam logic [1:0] HALTED  = 2'd3;

    // Instruction word the latch consumers substitute on flush or bubble.
    localparam logic [15:0] NOP_INSTR = 16'h0800;

endpackage

`default_nettype wire

// File: rtl/decode_hazard_ctrl_if.sv
// ============================================================================
// decode_hazard_ctrl_if : decode-side controls to/from the hazard sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface decode_hazard_ctrl_if
    import decode_hazard_ctrl_pkg::*;
#(
    parameter int REGW = decode_hazard_ctrl_pkg::REGW
);
    logic                 id_valid;
    logic [REGW-1:0]      id_rs_sel;
    logic                 id_rs_used;
    logic [REGW-1:0]      id_rt_sel;
    logic                 id_rt_used;
    logic [REGW-1:0]      id_wr_sel;
    logic                 id_wr_en;
    logic                 id_is_branch;
    logic                 id_halt;
    logic                 ex_resolve;
    logic                 ex_taken;
    logic                 fetch_enable;
    logic                 ifid_hold;
    logic                 id_bubble;
    logic                 ifid_flush;
    logic                 halted;
    logic [2**REGW-1:0]   busy_mask;

    modport master (
        output id_valid, id_rs_sel, id_rs_used, id_rt_sel, id_rt_used,
               id_wr_sel, id_wr_en, id_is_branch, id_halt, ex_resolve, ex_taken,
        input  fetch_enable, ifid_hold, id_bubble, ifid_flush, halted, busy_mask
    );

    modport slave (
        input  id_valid, id_rs_sel, id_rs_used, id_rt_sel, id_rt_used,
               id_wr_sel, id_wr_en, id_is_branch, id_halt, ex_resolve, ex_taken,
        output fetch_enable, ifid_hold, id_bubble, ifid_flush, halted, busy_mask
    );
endinterface

`default_nettype wire

// File: rtl/decode_hazard_ctrl_wr_scoreboard.sv
// ============================================================================
// decode_hazard_ctrl_wr_scoreboard : in-flight write shift register + match
// Revision: 1.0
// ============================================================================
`default_nettype none

module decode_hazard_ctrl_wr_scoreboard #(
    parameter int REGW  = decode_hazard_ctrl_pkg::REGW,
    parameter int DEPTH = decode_hazard_ctrl_pkg::DEPTH,
    parameter int CHECK = decode_hazard_ctrl_pkg::CHECK
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                push_v,
    input  wire logic [REGW-1:0]     push_sel,
    input  wire logic [REGW-1:0]     rs_sel,
    input  wire logic [REGW-1:0]     rt_sel,
    output logic                     rs_match,
    output logic                     rt_match,
    output logic                     empty,
    output logic [2**REGW-1:0]       busy_mask
);

    logic [DEPTH-1:0]           v_q;
    logic [DEPTH-1:0]           v_d;
    logic [DEPTH-1:0][REGW-1:0] sel_q;
    logic [DEPTH-1:0][REGW-1:0] sel_d;

    always_comb begin
        v_d      = '0;
        sel_d    = '0;
        v_d[0]   = push_v;
        sel_d[0] = push_sel;
        for (int i = 1; i < DEPTH; i++) begin
            v_d[i]   = v_q[i-1];
            sel_d[i] = sel_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q   <= '0;
            sel_q <= '0;
        end else begin
            v_q   <= v_d;
            sel_q <= sel_d;
        end
    end

    // Only the youngest CHECK entries matter; the register file bypasses WB.
    always_comb begin
        rs_match  = 1'b0;
        rt_match  = 1'b0;
        busy_mask = '0;
        for (int j = 0; j < CHECK; j++) begin
            if (v_q[j]) begin
                busy_mask[sel_q[j]] = 1'b1;
                if (sel_q[j] == rs_sel) rs_match = 1'b1;
                if (sel_q[j] == rt_sel) rt_match = 1'b1;
            end
        end
    end

    assign empty = ~|v_q;

endmodule

`default_nettype wire

// File: rtl/decode_hazard_ctrl.sv
// ============================================================================
// decode_hazard_ctrl : RAW stall, branch hold/flush and halt drain sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module decode_hazard_ctrl
    import decode_hazard_ctrl_pkg::*;
#(
    parameter int REGW  = decode_hazard_ctrl_pkg::REGW,
    parameter int DEPTH = decode_hazard_ctrl_pkg::DEPTH,
    parameter int CHECK = decode_hazard_ctrl_pkg::CHECK
) (
    input  wire logic          clk,
    input  wire logic          rst,
    decode_hazard_ctrl_if.slave hz
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       halted_q;
    logic       halted_d;

    logic       rs_match;
    logic       rt_match;
    logic       sb_empty;
    logic       hazard;
    logic       flush_now;
    logic       accept;

    assign hazard    = hz.id_valid & ((hz.id_rs_used & rs_match) | (hz.id_rt_used & rt_match));
    assign flush_now = (state_q == BR_WAIT) & hz.ex_resolve & hz.ex_taken;
    assign accept    = (state_q == RUN) & hz.id_valid & ~hazard & ~flush_now;

    decode_hazard_ctrl_wr_scoreboard #(
        .REGW  (REGW),
        .DEPTH (DEPTH),
        .CHECK (CHECK)
    ) u_wr_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .push_v    (accept & hz.id_wr_en),
        .push_sel  (hz.id_wr_sel),
        .rs_sel    (hz.id_rs_sel),
        .rt_sel    (hz.id_rt_sel),
        .rs_match  (rs_match),
        .rt_match  (rt_match),
        .empty     (sb_empty),
        .busy_mask (hz.busy_mask)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                // Halt outranks branch when both are flagged.
                if (accept && hz.id_halt)           state_d = DRAIN;
                else if (accept && hz.id_is_branch) state_d = BR_WAIT;
            end
            BR_WAIT: if (hz.ex_resolve) state_d = RUN;
            DRAIN:   if (sb_empty)      state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
        halted_d = halted_q | (state_d == HALTED);
    end

    always_comb begin
        hz.fetch_enable = 1'b1;
        hz.ifid_hold    = 1'b0;
        hz.id_bubble    = 1'b0;
        hz.ifid_flush   = 1'b0;
        case (state_q)
            RUN: begin
                if (hazard) begin
                    hz.fetch_enable = 1'b0;
                    hz.ifid_hold    = 1'b1;
                    hz.id_bubble    = 1'b1;
                end else if (accept && hz.id_halt) begin
                    // Nothing past the halt may be fetched.
                    hz.fetch_enable = 1'b0;
                    hz.ifid_hold    = 1'b1;
                end
            end
            BR_WAIT: begin
                hz.id_bubble = 1'b1;
                if (hz.ex_resolve) begin
                    hz.ifid_flush = hz.ex_taken;
                end else begin
                    hz.fetch_enable = 1'b0;
                    hz.ifid_hold    = 1'b1;
                end
            end
            default: begin
                hz.fetch_enable = 1'b0;
                hz.ifid_hold    = 1'b1;
                hz.id_bubble    = 1'b1;
            end
        endcase
    end

    assign hz.halted = halted_q;

endmodule

`default_nettype wire
